// File: rtl/tetris_pkg.sv
// Shared board geometry, colour types and palette for the Tetris pixel renderer.
package tetris_pkg;
  localparam int BOARD_COLS = 10;
  localparam int BOARD_ROWS = 20;
  localparam int CELL_SHIFT = 5;
  localparam int CELL_PX    = 1 << CELL_SHIFT;

  typedef logic [2:0]  color_idx_t;
  typedef logic [11:0] rgb444_t;

  localparam rgb444_t PALETTE [8] = '{12'h000, 12'h0FF, 12'hFF0, 12'hF0F,
                                      12'h0F0, 12'hF00, 12'h00F, 12'hF80};
  localparam rgb444_t BORDER_COLOR = 12'hFFF;
  localparam rgb444_t GRID_COLOR   = 12'h333;
  localparam rgb444_t BLANK_COLOR  = 12'h000;
endpackage

// File: rtl/tetris_board_renderer_if.sv
// Pixel stream between VGA timing generator, renderer and DAC: coordinates and syncs in, RGB and syncs out.
interface tetris_board_renderer_if;
  logic [10:0] curr_x;
  logic [9:0]  curr_y;
  logic        hsync_in;
  logic        vsync_in;
  logic [3:0]  vga_r;
  logic [3:0]  vga_g;
  logic [3:0]  vga_b;
  logic        hsync_out;
  logic        vsync_out;

  modport master (output curr_x, curr_y, hsync_in, vsync_in,
                  input  vga_r, vga_g, vga_b, hsync_out, vsync_out);
  modport slave  (input  curr_x, curr_y, hsync_in, vsync_in,
                  output vga_r, vga_g, vga_b, hsync_out, vsync_out);
endinterface

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with a configurable reset value, used to align side-band bits to the pixel pipeline.
module vga_delay_line #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [DEPTH-1:0][WIDTH-1:0] pipe_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe_q <= {DEPTH{RST_VAL}};
    end else begin
      pipe_q[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign dout = pipe_q[DEPTH-1];
endmodule

// File: rtl/tetris_board_renderer.sv
// Three-stage playfield renderer: cell fetch, piece overlay, colour select; syncs delayed to match.
// Define GRID_LINES_EN to draw a 1-pixel grid on the first row/column of every cell.
module tetris_board_renderer
  import tetris_pkg::*;
#(
  parameter int      BOARD_X0 = 480,
  parameter int      BOARD_Y0 = 80,
  parameter int      BORDER_W = 4,
  parameter rgb444_t BG_COLOR = 12'h112
) (
  input  logic                          clk,
  input  logic                          rst_n,
  tetris_board_renderer_if.slave        pix,
  output logic [7:0]                    cell_addr,
  input  color_idx_t                    cell_data,
  input  logic                          piece_valid,
  input  logic [19:0]                   piece_row,
  input  logic [15:0]                   piece_col,
  input  color_idx_t                    piece_color,
  output logic                          frame_start
);
  localparam logic [10:0] X_LO  = 11'(BOARD_X0);
  localparam logic [10:0] X_HI  = 11'(BOARD_X0 + BOARD_COLS*CELL_PX);
  localparam logic [10:0] XB_LO = 11'(BOARD_X0 - BORDER_W);
  localparam logic [10:0] XB_HI = 11'(BOARD_X0 + BOARD_COLS*CELL_PX + BORDER_W);
  localparam logic [9:0]  Y_LO  = 10'(BOARD_Y0);
  localparam logic [9:0]  Y_HI  = 10'(BOARD_Y0 + BOARD_ROWS*CELL_PX);
  localparam logic [9:0]  YB_LO = 10'(BOARD_Y0 - BORDER_W);
  localparam logic [9:0]  YB_HI = 10'(BOARD_Y0 + BOARD_ROWS*CELL_PX + BORDER_W);

  // S0: geometry decode
  logic [10:0] px, bx;
  logic [9:0]  by;
  logic        vis_d, inb_d, brd_d, grid_d;
  logic [3:0]  col_d;
  logic [4:0]  row_d;
  logic [7:0]  addr_d;

  always_comb begin
    px     = pix.curr_x - 11'd1;
    bx     = px - X_LO;
    by     = pix.curr_y - Y_LO;
    vis_d  = (pix.curr_x != 11'd0) && (pix.curr_x <= 11'd1280) && (pix.curr_y <= 10'd799);
    inb_d  = vis_d && (px >= X_LO) && (px < X_HI) && (pix.curr_y >= Y_LO) && (pix.curr_y < Y_HI);
    brd_d  = vis_d && !inb_d && (px >= XB_LO) && (px < XB_HI) &&
             (pix.curr_y >= YB_LO) && (pix.curr_y < YB_HI);
    col_d  = 4'(bx >> CELL_SHIFT);
    row_d  = 5'(by >> CELL_SHIFT);
    addr_d = inb_d ? 8'(row_d) * 8'(BOARD_COLS) + 8'(col_d) : 8'd0;
`ifdef GRID_LINES_EN
    grid_d = inb_d && ((bx[CELL_SHIFT-1:0] == '0) || (by[CELL_SHIFT-1:0] == '0));
`else
    grid_d = 1'b0;
`endif
  end

  logic       inb_q;
  logic [3:0] col_q;
  logic [4:0] row_q;
  logic [7:0] cell_addr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inb_q       <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      cell_addr_q <= '0;
    end else begin
      inb_q       <= inb_d;
      col_q       <= col_d;
      row_q       <= row_d;
      cell_addr_q <= addr_d;
    end
  end
  assign cell_addr = cell_addr_q;

  // Piece shadow is captured only at the vsync fall so a frame never shows a half-updated piece
  logic        vs_q, fs_q, sh_vld_q, vs_fall;
  logic [19:0] sh_row_q;
  logic [15:0] sh_col_q;
  color_idx_t  sh_color_q;

  assign vs_fall = vs_q & ~pix.vsync_in;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vs_q       <= 1'b0;
      fs_q       <= 1'b0;
      sh_vld_q   <= 1'b0;
      sh_row_q   <= '0;
      sh_col_q   <= '0;
      sh_color_q <= '0;
    end else begin
      vs_q <= pix.vsync_in;
      fs_q <= vs_fall;
      if (vs_fall) begin
        sh_vld_q   <= piece_valid;
        sh_row_q   <= piece_row;
        sh_col_q   <= piece_col;
        sh_color_q <= piece_color;
      end
    end
  end
  assign frame_start = fs_q;

  // S1: piece hit test
  logic hit_d, hit_q;
  always_comb begin
    hit_d = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (sh_vld_q && inb_q &&
          (sh_row_q[i*5 +: 5] == row_q) && (sh_col_q[i*4 +: 4] == col_q) &&
          (sh_row_q[i*5 +: 5] < 5'(BOARD_ROWS)) && (sh_col_q[i*4 +: 4] < 4'(BOARD_COLS)))
        hit_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) hit_q <= 1'b0;
    else        hit_q <= hit_d;
  end

  // S2: colour select; region flags ride a 2-deep delay line to meet cell_data
  logic vis2, brd2, inb2, grid2;
  vga_delay_line #(.WIDTH(4), .DEPTH(2), .RST_VAL(4'b0000)) u_flag_dly (
    .clk  (clk),
    .rst_n(rst_n),
    .din  ({vis_d, brd_d, inb_d, grid_d}),
    .dout ({vis2, brd2, inb2, grid2})
  );

  rgb444_t rgb_d, rgb_q;
  always_comb begin
    rgb_d = BLANK_COLOR;
    if (!vis2)                rgb_d = BLANK_COLOR;
    else if (brd2)            rgb_d = BORDER_COLOR;
    else if (hit_q)           rgb_d = PALETTE[sh_color_q];
    else if (inb2 && grid2)   rgb_d = GRID_COLOR;
    else if (inb2)            rgb_d = PALETTE[cell_data];
    else                      rgb_d = BG_COLOR;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rgb_q <= BLANK_COLOR;
    else        rgb_q <= rgb_d;
  end

  assign pix.vga_r = rgb_q[11:8];
  assign pix.vga_g = rgb_q[7:4];
  assign pix.vga_b = rgb_q[3:0];

  logic [1:0] sync_out;
  vga_delay_line #(.WIDTH(2), .DEPTH(3), .RST_VAL(2'b11)) u_sync_dly (
    .clk  (clk),
    .rst_n(rst_n),
    .din  ({pix.hsync_in, pix.vsync_in}),
    .dout (sync_out)
  );
  assign pix.hsync_out = sync_out[1];
  assign pix.vsync_out = sync_out[0];
endmodule

// File: tb/tb_tetris_board_renderer.sv
// Scoreboard bench: stimulus queues hand-computed expectations tagged with a cycle, a negedge monitor checks them.
module tb_tetris_board_renderer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  cell_addr;
  logic [2:0]  cell_data = 3'd0;
  logic        piece_valid;
  logic [19:0] piece_row;
  logic [15:0] piece_col;
  logic [2:0]  piece_color;
  logic        frame_start;
  logic [2:0]  ram [256];

  tetris_board_renderer_if pix_if ();

  tetris_board_renderer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix        (pix_if),
    .cell_addr  (cell_addr),
    .cell_data  (cell_data),
    .piece_valid(piece_valid),
    .piece_row  (piece_row),
    .piece_col  (piece_col),
    .piece_color(piece_color),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous board RAM: data one cycle after address
  always @(posedge clk) cell_data <= ram[cell_addr];

`ifdef GRID_LINES_EN
  localparam logic [11:0] E_PX480 = 12'h333;
  localparam logic [11:0] E_PX512 = 12'h333;
`else
  localparam logic [11:0] E_PX480 = 12'hFF0;
  localparam logic [11:0] E_PX512 = 12'h000;
`endif

  localparam int K_RGB = 0, K_HS = 1, K_VS = 2, K_ADDR = 3, K_FS = 4;

  typedef struct {
    int          cyc;
    int          kind;
    logic [11:0] val;
    string       nm;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void expect_at(int c, int k, logic [11:0] v, string nm);
    exp_t e;
    e.cyc = c; e.kind = k; e.val = v; e.nm = nm;
    exp_q.push_back(e);
  endfunction

  always @(negedge clk) begin
    logic [11:0] act;
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc == cyc) begin
        case (exp_q[i].kind)
          K_RGB:   act = {pix_if.vga_r, pix_if.vga_g, pix_if.vga_b};
          K_HS:    act = 12'(pix_if.hsync_out);
          K_VS:    act = 12'(pix_if.vsync_out);
          K_ADDR:  act = 12'(cell_addr);
          default: act = 12'(frame_start);
        endcase
        n_cmp++;
        if (act !== exp_q[i].val) begin
          n_bad++;
          $display("FAIL %s @cyc %0d: got %h want %h", exp_q[i].nm, cyc, act, exp_q[i].val);
        end
        exp_q.delete(i);
      end else if (exp_q[i].cyc < cyc) begin
        n_bad++;
        $display("FAIL %s: cycle %0d never sampled", exp_q[i].nm, exp_q[i].cyc);
        exp_q.delete(i);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pixv(input logic [10:0] x, input logic [9:0] y, input logic [11:0] rgb, input string nm);
    pix_if.curr_x = x;
    pix_if.curr_y = y;
    expect_at(cyc + 3, K_RGB, rgb, nm);
    tick();
  endtask

  task automatic pixa(input logic [10:0] x, input logic [9:0] y, input logic [11:0] rgb,
                      input logic [7:0] addr, input string nm);
    expect_at(cyc + 1, K_ADDR, 12'(addr), {nm, "_addr"});
    pixv(x, y, rgb, nm);
  endtask

  task automatic expect_reset_outputs(input int c, input string nm);
    expect_at(c, K_RGB,  12'h000, {nm, "_rgb"});
    expect_at(c, K_HS,   12'h001, {nm, "_hs"});
    expect_at(c, K_VS,   12'h001, {nm, "_vs"});
    expect_at(c, K_FS,   12'h000, {nm, "_fs"});
    expect_at(c, K_ADDR, 12'h000, {nm, "_addr"});
  endtask

  initial begin
    int f, r;
    for (int i = 0; i < 256; i++) ram[i] = 3'd0;
    ram[0] = 3'd2; ram[4] = 3'd2; ram[63] = 3'd6; ram[199] = 3'd3;

    rst_n = 1'b0;
    pix_if.curr_x = 11'd0; pix_if.curr_y = 10'd0;
    pix_if.hsync_in = 1'b1; pix_if.vsync_in = 1'b1;
    piece_valid = 1'b0; piece_row = '0; piece_col = '0; piece_color = '0;

    // Reset with toggling in-board inputs
    for (int k = 0; k < 5; k++) begin
      pix_if.curr_x   = (k % 2 == 1) ? 11'd621 : 11'd0;
      pix_if.curr_y   = 10'd90;
      pix_if.hsync_in = 1'(k % 2);
      pix_if.vsync_in = ~1'(k % 2);
      expect_reset_outputs(cyc + 1, "reset");
      tick();
    end
    rst_n = 1'b1;
    pix_if.curr_x = 11'd0; pix_if.hsync_in = 1'b1; pix_if.vsync_in = 1'b1;
    repeat (3) tick();

    // Fetch, border, background, blanking, grid
    pixa(11'd481,  10'd80,  E_PX480, 8'd0,   "fetch_first");
    pixa(11'd800,  10'd719, 12'hF0F, 8'd199, "fetch_last");
    pixa(11'd601,  10'd300, 12'h00F, 8'd63,  "fetch_mid");
    pixv(11'd477,  10'd200, 12'hFFF, "border_left");
    pixv(11'd471,  10'd200, 12'h112, "bg_left");
    pixv(11'd0,    10'd200, 12'h000, "blank_x0");
    pixv(11'd804,  10'd200, 12'hFFF, "border_right");
    pixv(11'd805,  10'd200, 12'h112, "bg_right");
    pixv(11'd601,  10'd723, 12'hFFF, "border_bottom");
    pixv(11'd601,  10'd724, 12'h112, "bg_bottom");
    pixv(11'd1280, 10'd0,   12'h112, "bg_lastcol");
    pixv(11'd1281, 10'd0,   12'h000, "blank_x1281");
    pixv(11'd601,  10'd800, 12'h000, "blank_y800");
    pixv(11'd513,  10'd100, E_PX512, "grid_px512");
    pixv(11'd514,  10'd100, 12'h000, "grid_px513");
    pix_if.curr_x = 11'd0;

    // Sync alignment
    while (cyc < 100) tick();
    pix_if.hsync_in = 1'b0;
    expect_at(102, K_HS, 12'h001, "hs_pre");
    expect_at(103, K_HS, 12'h000, "hs_low");
    expect_at(104, K_HS, 12'h001, "hs_post");
    tick();
    pix_if.hsync_in = 1'b1;
    tick();

    // Piece set mid-frame: blocks (0,4), (0,4) dup, (25,4) and (0,12) off-board
    piece_valid = 1'b1;
    piece_row   = {5'd0, 5'd25, 5'd0, 5'd0};
    piece_col   = {4'd12, 4'd4, 4'd4, 4'd4};
    piece_color = 3'd5;
    tick();
    pixv(11'd621, 10'd90, 12'hFF0, "piece_hidden");
    pixv(11'd621, 10'd90, 12'hFF0, "piece_hidden2");
    pix_if.curr_x = 11'd0;
    tick();

    f = cyc;
    pix_if.vsync_in = 1'b0;
    expect_at(f,     K_FS, 12'h000, "fs_before");
    expect_at(f + 1, K_FS, 12'h001, "fs_pulse");
    expect_at(f + 2, K_FS, 12'h000, "fs_after1");
    expect_at(f + 3, K_FS, 12'h000, "fs_after2");
    expect_at(f + 2, K_VS, 12'h001, "vs_pre");
    expect_at(f + 3, K_VS, 12'h000, "vs_low");
    tick();
    pixv(11'd621, 10'd90,  12'hF00, "piece_shown");
    pixv(11'd651, 10'd90,  12'h000, "piece_col5");
    pixv(11'd621, 10'd120, 12'h000, "piece_row1");
    pixv(11'd609, 10'd90,  12'hF00, "piece_over_grid");
    pix_if.vsync_in = 1'b1;
    expect_at(cyc + 3, K_VS, 12'h001, "vs_release");

    // Mid-frame piece change must not tear
    piece_color = 3'd1;
    piece_col   = {4'd12, 4'd4, 4'd4, 4'd5};
    pixv(11'd621, 10'd90, 12'hF00, "no_tear");
    expect_at(cyc + 1, K_FS, 12'h000, "fs_quiet");
    pixv(11'd651, 10'd90, 12'h000, "no_tear_col5");
    pix_if.curr_x = 11'd0;
    repeat (3) tick();

    // Reset mid-frame with vsync_in falling and held low through release
    r = cyc;
    rst_n = 1'b0;
    pix_if.curr_x = 11'd621; pix_if.curr_y = 10'd90;
    pix_if.hsync_in = 1'b0; pix_if.vsync_in = 1'b0;
    expect_reset_outputs(r + 1, "midrst1");
    expect_reset_outputs(r + 2, "midrst2");
    tick();
    tick();
    rst_n = 1'b1;
    pix_if.hsync_in = 1'b1;
    for (int k = 3; k <= 8; k++) expect_at(r + k, K_FS, 12'h000, "fs_masked");
    pixv(11'd621, 10'd90,  12'hFF0, "shadow_cleared");
    pixv(11'd601, 10'd300, 12'h00F, "post_rst_mid");
    pix_if.curr_x = 11'd0;
    while (cyc < r + 7) tick();
    pix_if.vsync_in = 1'b1;
    tick();
    tick();
    expect_at(cyc + 1, K_FS, 12'h001, "fs_fresh_edge");
    pix_if.vsync_in = 1'b0;
    tick();
    pix_if.vsync_in = 1'b1;
    repeat (4) tick();

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
    if (exp_q.size() != 0)
      $display("FAIL drain: %0d expectations left unchecked", exp_q.size());
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
